// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the FSM state type, the opcode/funct encodings, the ALU operation
// codes and the encodings for the ALU-B and PC-source mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_NAND = 3'b100;
    localparam logic [2:0] ALU_NOR  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct field decoder.
// Ports: funct (in)        - instr[5:0]
//        alu_control (out) - ALU operation for the funct; ADD when unknown
//        legal (out)       - 1 when funct is a supported R-type operation
module mips_alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] funct,
    output logic [2:0]       alu_control,
    output logic             legal
);

    always_comb begin
        alu_control = ALU_ADD;
        legal       = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_NOR:  alu_control = ALU_NOR;
            FN_SLT:  alu_control = ALU_SLT;
            default: legal       = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Ports: clk, rst_n (async active-low); opcode/funct from the instruction
// register; zero from the ALU; mem_ready memory handshake.
// Outputs: memory controls (mem_req, mem_write, iord), ir_write, PC control
// (pc_en, pc_src), ALU operand selects and op code, register-file controls
// (reg_write, reg_dst, mem_to_reg), illegal_op pulse and the retired
// instruction counter instr_count.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int OPC_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic [OPC_W-1:0] funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state_q, state_d;
    logic       pc_write, branch, retire;
    logic [2:0] fn_alu_control;
    logic       fn_legal;

    mips_alu_decoder #(.OPC_W(OPC_W)) u_alu_decoder (
        .funct       (funct),
        .alu_control (fn_alu_control),
        .legal       (fn_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instr_count <= '0;
        else if (retire) instr_count <= instr_count + CNT_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        pc_src      = PCSRC_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REGB;
        alu_control = ALU_AND;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        illegal_op  = 1'b0;
        retire      = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req     = 1'b1;
                alu_src_b   = SRCB_FOUR;
                alu_control = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b   = SRCB_IMM_SH;
                alu_control = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_IMM;
                alu_control = ALU_ADD;
                state_d     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_RTYPEEX: begin
                alu_src_a   = 1'b1;
                alu_control = fn_alu_control;
                if (fn_legal) begin
                    state_d = S_RTYPEWB;
                end else begin
                    illegal_op = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_RTYPEWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQEX: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = PCSRC_ALUOUT;
                branch      = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_IMM;
                alu_control = ALU_ADD;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JEX: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        pc_en = pc_write | (branch & zero);

        // The state register already sits in FETCH during reset; this
        // override silences FETCH's own strobes so nothing fires while
        // rst_n is low.
        if (!rst_n) begin
            mem_req     = 1'b0;
            mem_write   = 1'b0;
            iord        = 1'b0;
            ir_write    = 1'b0;
            pc_en       = 1'b0;
            pc_src      = PCSRC_ALU;
            alu_src_a   = 1'b0;
            alu_src_b   = SRCB_REGB;
            alu_control = ALU_ADD;
            reg_write   = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            illegal_op  = 1'b0;
            retire      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
        logic [3:0] instr_count;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       mem_req, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a;
    logic [2:0] alu_control;
    logic       reg_write, reg_dst, mem_to_reg, illegal_op;
    logic [3:0] instr_count;

    exp_t       obs;
    exp_t       sb[$];
    logic [3:0] exp_cnt;
    int         checks = 0;
    int         errors = 0;

    mips_multicycle_ctrl #(.CNT_W(4), .OPC_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
                  alu_src_b, alu_control, reg_write, reg_dst, mem_to_reg,
                  illegal_op, instr_count};

    // Expected outputs per state, written from the control table.
    function automatic exp_t e_zero();
        exp_t e = '0;
        return e;
    endfunction
    function automatic exp_t e_reset();
        exp_t e = '0;
        e.alu_control = 3'b010;
        return e;
    endfunction
    function automatic exp_t e_fetch(input bit rdy);
        exp_t e = '0;
        e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.alu_control = 3'b010;
        e.ir_write = rdy; e.pc_en = rdy;
        return e;
    endfunction
    function automatic exp_t e_decode(input bit ill);
        exp_t e = '0;
        e.alu_src_b = 2'b11; e.alu_control = 3'b010; e.illegal_op = ill;
        return e;
    endfunction
    function automatic exp_t e_ex_imm();
        exp_t e = '0;
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_control = 3'b010;
        return e;
    endfunction
    function automatic exp_t e_mem(input bit wr);
        exp_t e = '0;
        e.mem_req = 1'b1; e.iord = 1'b1; e.mem_write = wr;
        return e;
    endfunction
    function automatic exp_t e_wb(input bit dst, input bit m2r);
        exp_t e = '0;
        e.reg_write = 1'b1; e.reg_dst = dst; e.mem_to_reg = m2r;
        return e;
    endfunction
    function automatic exp_t e_rtypeex(input logic [2:0] ctl, input bit ill);
        exp_t e = '0;
        e.alu_src_a = 1'b1; e.alu_control = ctl; e.illegal_op = ill;
        return e;
    endfunction
    function automatic exp_t e_beq(input bit z);
        exp_t e = '0;
        e.alu_src_a = 1'b1; e.alu_control = 3'b110; e.pc_src = 2'b01; e.pc_en = z;
        return e;
    endfunction
    function automatic exp_t e_jex();
        exp_t e = '0;
        e.pc_src = 2'b10; e.pc_en = 1'b1;
        return e;
    endfunction

    // Inputs are already driven; push the expectation, compare at negedge,
    // then advance one clock.
    task automatic step(input exp_t e, input bit retire, input string name);
        exp_t want;
        e.instr_count = exp_cnt;
        sb.push_back(e);
        @(negedge clk);
        want = sb.pop_front();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, obs, want);
        end
        @(posedge clk);
        #1;
        if (retire) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic exec(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input int unsigned fetch_waits, input int unsigned mem_waits,
                        input string name);
        bit         legal_op;
        bit         legal_fn;
        logic [2:0] ctl;
        opcode = op; funct = fn; zero = z;
        for (int unsigned i = 0; i < fetch_waits; i++) begin
            mem_ready = 1'b0;
            step(e_fetch(1'b0), 1'b0, {name, " fetch-wait"});
        end
        mem_ready = 1'b1;
        step(e_fetch(1'b1), 1'b0, {name, " fetch"});
        legal_op = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
                   (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
        step(e_decode(!legal_op), 1'b0, {name, " decode"});
        if (!legal_op) return;
        case (op)
            6'b100011, 6'b101011: begin
                step(e_ex_imm(), 1'b0, {name, " memadr"});
                for (int unsigned i = 0; i < mem_waits; i++) begin
                    mem_ready = 1'b0;
                    step(e_mem(op == 6'b101011), 1'b0, {name, " mem-wait"});
                end
                mem_ready = 1'b1;
                if (op == 6'b101011) begin
                    step(e_mem(1'b1), 1'b1, {name, " memwr"});
                end else begin
                    step(e_mem(1'b0), 1'b0, {name, " memrd"});
                    step(e_wb(1'b0, 1'b1), 1'b1, {name, " memwb"});
                end
            end
            6'b000000: begin
                legal_fn = 1'b1;
                case (fn)
                    6'b100000: ctl = 3'b010;
                    6'b100010: ctl = 3'b110;
                    6'b100100: ctl = 3'b000;
                    6'b100101: ctl = 3'b001;
                    6'b100111: ctl = 3'b101;
                    6'b101010: ctl = 3'b111;
                    default: begin ctl = 3'b010; legal_fn = 1'b0; end
                endcase
                step(e_rtypeex(ctl, !legal_fn), 1'b0, {name, " rtypeex"});
                if (legal_fn) step(e_wb(1'b1, 1'b0), 1'b1, {name, " rtypewb"});
            end
            6'b000100: step(e_beq(z), 1'b1, {name, " beqex"});
            6'b001000: begin
                step(e_ex_imm(), 1'b0, {name, " addiex"});
                step(e_wb(1'b0, 1'b0), 1'b1, {name, " addiwb"});
            end
            default: step(e_jex(), 1'b1, {name, " jex"});
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b100011; funct = '0; zero = 1'b0;
        exp_cnt = '0;
        step(e_reset(), 1'b0, "reset0");
        step(e_reset(), 1'b0, "reset1");
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        exec(6'b100011, 6'b000000, 1'b0, 0, 0, "lw");
        exec(6'b100011, 6'b000000, 1'b0, 0, 2, "lw_stall");
    endtask

    task automatic test_rtype();
        logic [5:0] fns [6] = '{6'b101010, 6'b100111, 6'b100000,
                                6'b100010, 6'b100100, 6'b100101};
        foreach (fns[i]) exec(6'b000000, fns[i], 1'b0, 0, 0, "rtype");
    endtask

    task automatic test_beq();
        exec(6'b000100, 6'b000000, 1'b1, 0, 0, "beq_taken");
        exec(6'b000100, 6'b000000, 1'b0, 0, 0, "beq_not_taken");
    endtask

    task automatic test_sw_stall();
        exec(6'b101011, 6'b000000, 1'b0, 2, 3, "sw_stall");
    endtask

    task automatic test_addi_j();
        exec(6'b001000, 6'b000000, 1'b0, 0, 0, "addi");
        exec(6'b000010, 6'b000000, 1'b0, 0, 0, "j");
    endtask

    task automatic test_illegal();
        exec(6'b111111, 6'b000000, 1'b0, 0, 0, "bad_opcode");
        exec(6'b000000, 6'b000000, 1'b0, 0, 0, "bad_funct");
    endtask

    task automatic test_reset_mid();
        opcode = 6'b100011; funct = '0; mem_ready = 1'b1;
        step(e_fetch(1'b1), 1'b0, "mid fetch");
        step(e_decode(1'b0), 1'b0, "mid decode");
        step(e_ex_imm(), 1'b0, "mid memadr");
        mem_ready = 1'b0;
        step(e_mem(1'b0), 1'b0, "mid memrd");
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        mem_ready = 1'b1;
        step(e_reset(), 1'b0, "mid reset");
        rst_n = 1'b1;
        exec(6'b000010, 6'b000000, 1'b0, 0, 0, "post_reset_j");
    endtask

    task automatic test_back_to_back_wrap();
        // Counter is 4 bits here: enough jumps to pass 15 and wrap to 0.
        for (int unsigned i = 0; i < 16; i++)
            exec(6'b000010, 6'b000000, 1'b0, 0, 0, "wrap_j");
        exec(6'b001000, 6'b000000, 1'b0, 0, 0, "after_wrap_addi");
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_sw_stall();
        test_addi_j();
        test_illegal();
        test_reset_mid();
        test_back_to_back_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
